mux8_1_rr_collector: RTL and testbench
======================================

Name: mux8_1_rr_collector

Overview:
- 8-input to 1-output collector with round-robin arbitration; the gathering counterpart to the 1:8 demux fan-out.
- Each cycle it picks one requesting input lane, registers that lane's data, and presents it downstream together with the 3-bit lane index.
- The index output can drive a downstream 1:8 demux select directly.
- Sits between eight independent producers and a single shared consumer.

Parameters:
- DW, 8, data width per lane in bits (1 or more).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8*DW  lane i occupies bits [i*DW +: DW].
- in_valid  input  8  lane i has a word to offer.
- in_ready  output  8  one-hot or zero; lane i's word is accepted this cycle.
- out_data  output  DW  registered data of the held word.
- out_sel  output  3  lane index of the held word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the held word this cycle.

Behaviour:
- Reset (async assert, sync deassert handled externally): out_valid=0, out_data=0, out_sel=0, last-grant pointer ptr=7, FSM=EMPTY.
- Because ptr resets to 7, lane 0 has the highest priority after reset.
- FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = (state==EMPTY) | out_ready. A full register that is drained in the same cycle can reload, giving 1 word/cycle throughput.
- Arbitration (combinational):
  - Search in_valid starting at index (ptr+1) mod 8, ascending with wrap 7->0.
  - The first set bit is the winner g.
  - in_ready = load ? onehot(g) : 0. in_ready is 0 when in_valid is 0.
  - in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer: when in_valid[g] & in_ready[g], on the next edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - ptr <= g
  - state <= FULL
- Drain without reload: when FULL, out_ready=1 and no in_valid, then next state=EMPTY. out_data and out_sel keep their last values (don't-care while out_valid=0).
- Stall: when FULL and out_ready=0, out_data, out_sel, out_valid and ptr are all held stable, and in_ready=0.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N (1 cycle).
- Fairness: with all 8 lanes continuously valid and out_ready=1, grants are 0,1,...,7,0,... Each lane waits at most 7 transfers.
- ptr changes only on an accepted input, never on stalls or idle cycles.
- Lanes must hold in_valid and in_data stable until accepted; the block does not check this.
- Reset mid-operation: the held word is discarded, out_valid drops immediately (async), and ptr returns to 7.
- Implementation guidance: a single always block for state/ptr/out regs and a combinational priority search. Expected size is roughly 120-200 lines.

Test Plan:
- Reset then single lane: hold rst_n=0, then release; set in_valid=8'b0000_1000 with lane 3 data 8'hA5 and out_ready=1. Expect in_ready=8'b0000_1000 in that cycle, then out_valid=1, out_data=8'hA5, out_sel=3 on the next cycle, then out_valid=0.
- Round-robin full load: all in_valid=8'hFF, lane i data = 8'h10+i, out_ready=1 for 16 cycles. Expect out_sel sequence 0..7,0..7, matching data, and out_valid continuously 1 after the first cycle.
- Backpressure: FULL with out_sel=2 and data 8'h12; drop out_ready for 5 cycles while in_valid=8'hFF. Expect in_ready=0, and out_data/out_sel/out_valid unchanged. When out_ready returns, the next out_sel is 3.
- Wrap-around priority: after lane 6 is granted, set in_valid=8'b0100_0011. Expect grant order 0, 1, 6 (search from 7 wraps to 0).
- Drain to empty: FULL, out_ready=1, in_valid=0. Expect out_valid=0 next cycle and ptr unchanged. Then in_valid=8'b0000_0001 yields out_sel=0.
- Async reset mid-stream: assert rst_n=0 between edges while FULL. Expect out_valid=0 immediately without waiting for clk. After release with in_valid=8'hFF, the first out_sel is 0.

Source files
------------

// File: rtl/mux8_1_rr_collector.sv
// ----------------------------------------------------------------------------
// mux8_1_rr_collector
//
// Gathers words from eight independent producer lanes into a single output
// register using round-robin arbitration. Each cycle in which the output
// register can load, one requesting lane is granted. Its word is registered
// and presented downstream together with its 3-bit lane index. The index can
// drive a downstream 1:8 demux select directly.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data_i    8*DW packed lane data, lane i at [i*DW +: DW]
//   in_valid_i   per-lane word-available flags
//   in_ready_o   one-hot (or zero) grant; lane i's word is accepted this cycle
//   out_data_o   registered data of the held word
//   out_sel_o    lane index of the held word
//   out_valid_o  output register holds a word
//   out_ready_i  consumer accepts the held word this cycle
// ----------------------------------------------------------------------------
module mux8_1_rr_collector #(
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8*DW-1:0] in_data_i,
    input  logic [7:0]      in_valid_i,
    output logic [7:0]      in_ready_o,
    output logic [DW-1:0]   out_data_o,
    output logic [2:0]      out_sel_o,
    output logic            out_valid_o,
    input  logic            out_ready_i
);

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      ptr_q;
    logic [DW-1:0]   out_data_q;
    logic [2:0]      out_sel_q;

    logic [DW-1:0]   lane_data [8];
    logic            load;
    logic            found;
    logic [2:0]      grant;
    logic [2:0]      cand;
    logic            accept;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane_data[i] = in_data_i[i*DW +: DW];
    end

    // A full register drained this cycle can reload, giving one word per cycle.
    assign load = (state_q == StEmpty) || out_ready_i;

    // Priority search starting just after the last granted lane, wrapping 7->0.
    always_comb begin
        found = 1'b0;
        grant = 3'd0;
        cand  = 3'd0;
        for (int unsigned k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k) + 3'd1;
            if (!found && in_valid_i[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign accept = load && found;

    always_comb begin
        in_ready_o = 8'd0;
        if (accept) begin
            in_ready_o[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StFull;
        end else if (state_q == StFull && out_ready_i) begin
            state_d = StEmpty;
        end
    end

    // Data, index and pointer only move on an accepted word; stalls and idle
    // cycles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            ptr_q      <= 3'd7;
            out_data_q <= '0;
            out_sel_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_data_q <= lane_data[grant];
                out_sel_q  <= grant;
                ptr_q      <= grant;
            end
        end
    end

    assign out_valid_o = (state_q == StFull);
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_mux8_1_rr_collector.sv
module tb_mux8_1_rr_collector;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [8*DW-1:0] in_data;
    logic [7:0]      in_valid;
    logic [7:0]      in_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_sel;
    logic            out_valid;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: a one-word buffer plus "last lane served".
    bit          m_full;
    logic [7:0]  m_data;
    int          m_sel;
    int          m_ptr;

    mux8_1_rr_collector #(.DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    // Lane that the model would serve now, or -1 if nothing is accepted.
    function automatic int m_winner();
        if (m_full && !out_ready) return -1;
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (m_ptr + k) % 8;
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_ready();
        logic [7:0] r;
        int g;
        r = 8'd0;
        g = m_winner();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_data = 8'd0;
        m_sel  = 0;
        m_ptr  = 7;
    endtask

    // Advance one clock; the model consumes the same inputs the DUT sampled.
    task automatic tick(output int g);
        @(posedge clk);
        g = m_winner();
        if (g >= 0) begin
            m_full = 1;
            m_sel  = g;
            m_ptr  = g;
            m_data = in_data[g*DW +: DW];
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int g;
        rst_n     = 1'b0;
        in_valid  = 8'd0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 3'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b sel=%0d data=%h, want v=0 sel=0 data=00",
                     out_valid, out_sel, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(g);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle: got v=%b rdy=%b, want v=0 rdy=00000000",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_single_lane();
        int g;
        apply_reset();
        in_valid  = 8'b0000_1000;
        in_data   = {8{8'h5A}};
        in_data[3*DW +: DW] = 8'hA5;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'b0000_1000 || in_ready !== m_ready()) begin
            errors++;
            $display("FAIL single_ready: got rdy=%b, want rdy=00001000", in_ready);
        end
        tick(g);
        in_valid = 8'd0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 3'd3, 8'hA5}) begin
            errors++;
            $display("FAIL single_out: got v=%b sel=%0d data=%h, want v=1 sel=3 data=a5",
                     out_valid, out_sel, out_data);
        end
        tick(g);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        int g;
        apply_reset();
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = 8'h10 + 8'(i);
        for (int n = 0; n < 16; n++) begin
            tick(g);
            @(negedge clk);
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 3'(n % 8), 8'h10 + 8'(n % 8)} ||
                in_ready !== m_ready()) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got v=%b sel=%0d data=%h rdy=%b, want v=1 sel=%0d data=%h rdy=%b",
                         n, out_valid, out_sel, out_data, in_ready, n % 8, 8'h10 + 8'(n % 8),
                         m_ready());
            end
        end
    endtask

    task automatic test_backpressure();
        int g;
        apply_reset();
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = 8'h10 + 8'(i);
        repeat (3) tick(g);
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 3'd2, 8'h12, 8'd0}) begin
                errors++;
                $display("FAIL stall[%0d]: got v=%b sel=%0d data=%h rdy=%b, want v=1 sel=2 data=12 rdy=0",
                         n, out_valid, out_sel, out_data, in_ready);
            end
            tick(g);
        end
        out_ready = 1'b1;
        tick(g);
        @(negedge clk);
        checks++;
        if (out_sel !== 3'd3 || out_data !== 8'h13 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got v=%b sel=%0d data=%h, want v=1 sel=3 data=13",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_wrap_and_drain();
        int g;
        int exp_seq [3] = '{0, 1, 6};
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = 8'($urandom);
        in_valid = 8'b0100_0000;
        tick(g);
        in_valid = 8'b0100_0011;
        for (int n = 0; n < 3; n++) begin
            tick(g);
            if (g >= 0) in_valid[g] = 1'b0;
            @(negedge clk);
            checks++;
            if (out_sel !== 3'(exp_seq[n]) || out_valid !== 1'b1 ||
                out_data !== in_data[exp_seq[n]*DW +: DW]) begin
                errors++;
                $display("FAIL wrap[%0d]: got v=%b sel=%0d data=%h, want v=1 sel=%0d data=%h",
                         n, out_valid, out_sel, out_data, exp_seq[n],
                         in_data[exp_seq[n]*DW +: DW]);
            end
        end
        // Now holding lane 6; drain, idle a while, the pointer must stay at 6.
        in_valid = 8'd0;
        repeat (3) tick(g);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got v=%b, want v=0", out_valid);
        end
        in_valid = 8'hFF;
        tick(g);
        @(negedge clk);
        checks++;
        if (out_sel !== 3'd7 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_ptr_held: got v=%b sel=%0d, want v=1 sel=7", out_valid, out_sel);
        end
        in_valid = 8'd0;
        tick(g);
        in_valid = 8'b0000_0001;
        tick(g);
        @(negedge clk);
        checks++;
        if (out_sel !== 3'd0 || out_valid !== 1'b1 || out_data !== in_data[0 +: DW]) begin
            errors++;
            $display("FAIL drain_lane0: got v=%b sel=%0d data=%h, want v=1 sel=0 data=%h",
                     out_valid, out_sel, out_data, in_data[0 +: DW]);
        end
    endtask

    task automatic test_async_reset();
        int g;
        apply_reset();
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = 8'($urandom);
        repeat (4) tick(g);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 3'd0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b sel=%0d data=%h, want v=0 sel=0 data=00",
                     out_valid, out_sel, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 8'b0000_0001) begin
            errors++;
            $display("FAIL async_rel_ready: got rdy=%b, want rdy=00000001", in_ready);
        end
        tick(g);
        @(negedge clk);
        checks++;
        if (out_sel !== 3'd0 || out_valid !== 1'b1 || out_data !== in_data[0 +: DW]) begin
            errors++;
            $display("FAIL async_first: got v=%b sel=%0d data=%h, want v=1 sel=0 data=%h",
                     out_valid, out_sel, out_data, in_data[0 +: DW]);
        end
    endtask

    // Random producers and consumer; lanes hold their word until granted.
    task automatic test_random();
        int g;
        apply_reset();
        in_valid  = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = 8'($urandom);
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) begin
                if (!in_valid[i] && ($urandom % 3 == 0)) begin
                    in_valid[i] = 1'b1;
                    in_data[i*DW +: DW] = 8'($urandom);
                end
            end
            out_ready = ($urandom % 4 != 0);
            #1;
            checks++;
            if ({out_valid, out_sel, out_data, in_ready} !==
                {m_full, 3'(m_sel), m_data, m_ready()}) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b sel=%0d data=%h rdy=%b, want v=%b sel=%0d data=%h rdy=%b",
                         n, out_valid, out_sel, out_data, in_ready, m_full, m_sel, m_data,
                         m_ready());
            end
            tick(g);
            if (g >= 0) in_valid[g] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_wrap_and_drain();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
